// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in serial-out serializer.
//   piso_state_e  - two-state control FSM encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH - default word length in bits
package piso_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter with a zero flag.
// Counts the bits still to be emitted after the one currently on the line.
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset, clears the count
//   load       - load load_value (has priority over dec)
//   load_value - value loaded on load
//   dec        - decrement by one (saturates at zero)
//   zero       - count is zero
module piso_bit_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out serializer with valid/ready load.
// A word is accepted on any edge with load_valid & load_ready; its first bit
// appears on shift_out the following cycle, one bit per cycle after that.
// A new word can be accepted on the last-bit cycle, giving gapless streams.
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   data_in      - parallel word to serialize
//   load_valid   - data_in holds a word to accept
//   load_ready   - a word is accepted on this edge if load_valid is high
//   shift_out    - registered serial bit stream (0 when idle)
//   frame_active - shift_out carries a valid data bit
//   last_bit     - shift_out carries the final bit of the word
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             shift_out,
  output logic             frame_active,
  output logic             last_bit
);

  localparam int unsigned CW = $clog2(WIDTH);

  piso_state_e      state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic             shift_next;
  logic             transfer;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  piso_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (CW'(WIDTH - 1)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // cnt is zero in IDLE as well, but state is tested explicitly for clarity.
  assign load_ready   = (state == IDLE) || cnt_zero;
  assign transfer     = load_valid && load_ready;
  assign frame_active = (state == SHIFT);
  assign last_bit     = frame_active && cnt_zero;

  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    shift_next = shift_out;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (transfer) begin
      // First bit goes straight to the output register; sreg keeps the rest.
      state_next = SHIFT;
      cnt_load   = 1'b1;
      if (MSB_FIRST) begin
        shift_next = data_in[WIDTH-1];
        sreg_next  = {data_in[WIDTH-2:0], 1'b0};
      end else begin
        shift_next = data_in[0];
        sreg_next  = {1'b0, data_in[WIDTH-1:1]};
      end
    end else if (state == SHIFT && !cnt_zero) begin
      cnt_dec = 1'b1;
      if (MSB_FIRST) begin
        shift_next = sreg[WIDTH-1];
        sreg_next  = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        shift_next = sreg[0];
        sreg_next  = {1'b0, sreg[WIDTH-1:1]};
      end
    end else if (state == SHIFT) begin
      // Last bit done and nothing to load: drop back to a quiet line.
      state_next = IDLE;
      shift_next = 1'b0;
      sreg_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      shift_out <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      shift_out <= shift_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed, table-driven bench for piso_serializer.
// Two instances (MSB-first and LSB-first) share clock, reset and inputs;
// each check looks at the instance selected by sel_lsb.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;

  logic ready_m, so_m, fa_m, lb_m;
  logic ready_l, so_l, fa_l, lb_l;

  bit   sel_lsb;
  logic ready, so, fa, lb;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (ready_m),
    .shift_out    (so_m),
    .frame_active (fa_m),
    .last_bit     (lb_m)
  );

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (ready_l),
    .shift_out    (so_l),
    .frame_active (fa_l),
    .last_bit     (lb_l)
  );

  assign ready = sel_lsb ? ready_l : ready_m;
  assign so    = sel_lsb ? so_l    : so_m;
  assign fa    = sel_lsb ? fa_l    : fa_m;
  assign lb    = sel_lsb ? lb_l    : lb_m;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         lsb;
    logic [7:0] exp_bits;  // emission order, exp_bits[7] leaves first
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle shift_out"}, so, 0);
    chk({tag, " idle frame_active"}, fa, 0);
    chk({tag, " idle last_bit"}, lb, 0);
    chk({tag, " idle load_ready"}, ready, 1);
  endtask

  // Called at the negedge after the transfer edge; ends one negedge past the last bit.
  task automatic check_word(input string tag, input logic [7:0] exp_bits);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s bit%0d shift_out", tag, i), so, exp_bits[7-i]);
      chk($sformatf("%s bit%0d frame_active", tag, i), fa, 1);
      chk($sformatf("%s bit%0d last_bit", tag, i), lb, (i == 7) ? 1 : 0);
      chk($sformatf("%s bit%0d load_ready", tag, i), ready, (i == 7) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{"msb_a5", 8'hA5, 1'b0, 8'b1010_0101};
    vecs[1] = '{"msb_3c", 8'h3C, 1'b0, 8'b0011_1100};
    vecs[2] = '{"msb_01", 8'h01, 1'b0, 8'b0000_0001};
    vecs[3] = '{"lsb_01", 8'h01, 1'b1, 8'b1000_0000};
    vecs[4] = '{"lsb_c1", 8'hC1, 1'b1, 8'b1000_0011};
    vecs[5] = '{"lsb_80", 8'h80, 1'b1, 8'b0000_0001};

    rst        = 1'b1;
    data_in    = 8'h00;
    load_valid = 1'b0;
    sel_lsb    = 1'b0;

    // Reset values before any clock edge.
    #2;
    check_idle("reset_msb");
    sel_lsb = 1'b1;
    check_idle("reset_lsb");
    sel_lsb = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Single-word loads from the table.
    foreach (vecs[k]) begin
      sel_lsb    = vecs[k].lsb;
      data_in    = vecs[k].data;
      load_valid = 1'b1;
      chk({vecs[k].name, " ready_before"}, ready, 1);
      @(negedge clk);
      load_valid = 1'b0;
      data_in    = ~vecs[k].data;  // must not disturb the word in flight
      check_word(vecs[k].name, vecs[k].exp_bits);
      check_idle(vecs[k].name);
    end
    sel_lsb = 1'b0;

    // Back-to-back A5 then 3C with load_valid held high.
    data_in    = 8'hA5;
    load_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h3C;
    check_word("b2b_w1", 8'hA5);
    load_valid = 1'b0;
    data_in    = 8'h00;
    check_word("b2b_w2", 8'h3C);
    check_idle("b2b");

    // Word 0x00 with 0xFF offered throughout: only taken on the last-bit cycle.
    data_in    = 8'h00;
    load_valid = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    check_word("busy_w0", 8'h00);
    load_valid = 1'b0;
    check_word("busy_wff", 8'hFF);
    check_idle("busy");

    // Asynchronous reset after 3 bits of A5.
    data_in    = 8'hA5;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_mid bit%0d", i), so, vecs[0].exp_bits[7-i]);
      @(negedge clk);
    end
    chk("rst_mid frame_before", fa, 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    check_idle("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_released");
    data_in    = 8'h3C;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check_word("after_rst", 8'h3C);
    check_idle("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
